// File: rtl/ctrl_msg_arbiter.sv
// Round-robin merger of GameControl handler control-message requests onto the
// single ctrl_* bus, pacing issues against the interboard transmitter's ready cycle.
module ctrl_msg_arbiter #(
  parameter int N_SRC        = 4,
  parameter int BUSY_TIMEOUT = 3
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               interboard_rst,
  input  logic               inter_ready,
  input  logic [N_SRC-1:0]   src_en,
  input  logic [N_SRC-1:0]   src_move_dir,
  input  logic [4*N_SRC-1:0] src_msg_type,
  input  logic [6*N_SRC-1:0] src_card,
  input  logic [3*N_SRC-1:0] src_sel_len,
  input  logic [5*N_SRC-1:0] src_block_x,
  input  logic [3*N_SRC-1:0] src_block_y,
  output logic               ctrl_en,
  output logic               ctrl_move_dir,
  output logic [3:0]         ctrl_msg_type,
  output logic [5:0]         ctrl_card,
  output logic [2:0]         ctrl_sel_len,
  output logic [4:0]         ctrl_block_x,
  output logic [2:0]         ctrl_block_y,
  output logic [N_SRC-1:0]   pending,
  output logic [N_SRC-1:0]   overflow,
  output logic               busy
);

  localparam int IDX_W = (N_SRC > 1) ? $clog2(N_SRC) : 1;
  localparam int CNT_W = (BUSY_TIMEOUT > 1) ? $clog2(BUSY_TIMEOUT) : 1;
  localparam logic [IDX_W-1:0] LAST_INIT = IDX_W'(N_SRC - 1);
  localparam logic [CNT_W-1:0] CNT_LAST  = CNT_W'(BUSY_TIMEOUT - 1);

  typedef struct packed {
    logic       move_dir;
    logic [3:0] msg_type;
    logic [5:0] card;
    logic [2:0] sel_len;
    logic [4:0] block_x;
    logic [2:0] block_y;
  } msg_t;

  typedef enum logic [1:0] {
    ST_IDLE      = 2'd0,
    ST_SEND      = 2'd1,
    ST_WAIT_BUSY = 2'd2,
    ST_WAIT_DONE = 2'd3
  } state_t;

  state_t           state_q, state_d;
  logic [N_SRC-1:0] pending_q, pending_d;
  logic [N_SRC-1:0] overflow_q, overflow_d;
  logic [IDX_W-1:0] last_grant_q, last_grant_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  msg_t             buf_q [N_SRC];
  msg_t             buf_d [N_SRC];
  msg_t             ctrl_q, ctrl_d;
  logic             ctrl_en_q, ctrl_en_d;
  logic             busy_q, busy_d;

  msg_t             src_msg [N_SRC];
  logic [IDX_W-1:0] winner;
  logic             found;
  logic             grant;

  always_comb begin
    for (int i = 0; i < N_SRC; i++) begin
      src_msg[i].move_dir = src_move_dir[i];
      src_msg[i].msg_type = src_msg_type[i*4 +: 4];
      src_msg[i].card     = src_card[i*6 +: 6];
      src_msg[i].sel_len  = src_sel_len[i*3 +: 3];
      src_msg[i].block_x  = src_block_x[i*5 +: 5];
      src_msg[i].block_y  = src_block_y[i*3 +: 3];
    end
  end

  // Scan starts just after the previous winner so every pending source gets a turn.
  always_comb begin
    winner = last_grant_q;
    found  = 1'b0;
    for (int k = 1; k <= N_SRC; k++) begin
      int idx;
      idx = (int'(last_grant_q) + k) % N_SRC;
      if (!found && pending_q[idx]) begin
        winner = IDX_W'(idx);
        found  = 1'b1;
      end
    end
  end

  assign grant = (state_q == ST_IDLE) && (|pending_q) && inter_ready;

  always_comb begin
    state_d      = state_q;
    pending_d    = pending_q;
    overflow_d   = overflow_q;
    last_grant_d = last_grant_q;
    cnt_d        = cnt_q;
    buf_d        = buf_q;
    ctrl_d       = ctrl_q;
    ctrl_en_d    = 1'b0;

    case (state_q)
      ST_IDLE: begin
        if (grant) begin
          state_d      = ST_SEND;
          ctrl_en_d    = 1'b1;
          ctrl_d       = buf_q[winner];
          last_grant_d = winner;
        end
      end
      ST_SEND: begin
        state_d = ST_WAIT_BUSY;
        cnt_d   = '0;
      end
      ST_WAIT_BUSY: begin
        if (!inter_ready) begin
          state_d = ST_WAIT_DONE;
        end else if (cnt_q == CNT_LAST) begin
          state_d = ST_IDLE;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      ST_WAIT_DONE: begin
        if (inter_ready) state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase

    // A granted entry is read out this edge, so a same-cycle request may refill it.
    for (int i = 0; i < N_SRC; i++) begin
      logic granted;
      granted = grant && (winner == IDX_W'(i));
      if (src_en[i]) begin
        if (!pending_q[i] || granted) begin
          buf_d[i]     = src_msg[i];
          pending_d[i] = 1'b1;
        end else begin
          overflow_d[i] = 1'b1;
        end
      end else if (granted) begin
        pending_d[i] = 1'b0;
      end
    end

    busy_d = (state_d != ST_IDLE);
  end

  always_ff @(posedge clk) begin
    if (rst || interboard_rst) begin
      state_q      <= ST_IDLE;
      pending_q    <= '0;
      overflow_q   <= '0;
      last_grant_q <= LAST_INIT;
      cnt_q        <= '0;
      ctrl_q       <= '0;
      ctrl_en_q    <= 1'b0;
      busy_q       <= 1'b0;
      for (int i = 0; i < N_SRC; i++) buf_q[i] <= '0;
    end else begin
      state_q      <= state_d;
      pending_q    <= pending_d;
      overflow_q   <= overflow_d;
      last_grant_q <= last_grant_d;
      cnt_q        <= cnt_d;
      ctrl_q       <= ctrl_d;
      ctrl_en_q    <= ctrl_en_d;
      busy_q       <= busy_d;
      for (int i = 0; i < N_SRC; i++) buf_q[i] <= buf_d[i];
    end
  end

  assign ctrl_en       = ctrl_en_q;
  assign ctrl_move_dir = ctrl_q.move_dir;
  assign ctrl_msg_type = ctrl_q.msg_type;
  assign ctrl_card     = ctrl_q.card;
  assign ctrl_sel_len  = ctrl_q.sel_len;
  assign ctrl_block_x  = ctrl_q.block_x;
  assign ctrl_block_y  = ctrl_q.block_y;
  assign pending       = pending_q;
  assign overflow      = overflow_q;
  assign busy          = busy_q;

endmodule

// File: tb/tb_ctrl_msg_arbiter.sv
// Directed bench for ctrl_msg_arbiter: single issue, round-robin order, overflow,
// refill-on-grant, ready timeout and mid-operation reset.
module tb_ctrl_msg_arbiter;

  localparam int N_SRC = 4;

  logic               clk = 1'b0;
  logic               rst = 1'b1;
  logic               interboard_rst = 1'b0;
  logic               inter_ready = 1'b1;
  logic [N_SRC-1:0]   src_en = '0;
  logic [N_SRC-1:0]   src_move_dir = '0;
  logic [4*N_SRC-1:0] src_msg_type = '0;
  logic [6*N_SRC-1:0] src_card = '0;
  logic [3*N_SRC-1:0] src_sel_len = '0;
  logic [5*N_SRC-1:0] src_block_x = '0;
  logic [3*N_SRC-1:0] src_block_y = '0;
  logic               ctrl_en;
  logic               ctrl_move_dir;
  logic [3:0]         ctrl_msg_type;
  logic [5:0]         ctrl_card;
  logic [2:0]         ctrl_sel_len;
  logic [4:0]         ctrl_block_x;
  logic [2:0]         ctrl_block_y;
  logic [N_SRC-1:0]   pending;
  logic [N_SRC-1:0]   overflow;
  logic               busy;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  ctrl_msg_arbiter #(.N_SRC(N_SRC), .BUSY_TIMEOUT(3)) dut (
    .clk(clk), .rst(rst), .interboard_rst(interboard_rst), .inter_ready(inter_ready),
    .src_en(src_en), .src_move_dir(src_move_dir), .src_msg_type(src_msg_type),
    .src_card(src_card), .src_sel_len(src_sel_len), .src_block_x(src_block_x),
    .src_block_y(src_block_y), .ctrl_en(ctrl_en), .ctrl_move_dir(ctrl_move_dir),
    .ctrl_msg_type(ctrl_msg_type), .ctrl_card(ctrl_card), .ctrl_sel_len(ctrl_sel_len),
    .ctrl_block_x(ctrl_block_x), .ctrl_block_y(ctrl_block_y), .pending(pending),
    .overflow(overflow), .busy(busy)
  );

  task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic set_src(input int i, input logic dir, input logic [3:0] mt, input logic [5:0] card,
                         input logic [2:0] sl, input logic [4:0] bx, input logic [2:0] by);
    src_move_dir[i]         = dir;
    src_msg_type[i*4 +: 4]  = mt;
    src_card[i*6 +: 6]      = card;
    src_sel_len[i*3 +: 3]   = sl;
    src_block_x[i*5 +: 5]   = bx;
    src_block_y[i*3 +: 3]   = by;
  endtask

  task automatic pulse(input logic [N_SRC-1:0] mask);
    src_en = mask;
    tick();
    src_en = '0;
  endtask

  task automatic do_reset();
    rst    = 1'b1;
    src_en = '0;
    tick();
    tick();
    rst = 1'b0;
  endtask

  task automatic expect_issue(input string tag, input logic [5:0] exp_card);
    tick();
    check_val({tag, "_en"}, 32'(ctrl_en), 32'd1);
    check_val({tag, "_card"}, 32'(ctrl_card), 32'(exp_card));
  endtask

  // Transmitter goes busy for one cycle after SEND, then idle; ends in an IDLE cycle.
  task automatic xmit_cycle();
    inter_ready = 1'b0;
    tick();
    check_val("xmit_no_repeat", 32'(ctrl_en), 32'd0);
    tick();
    inter_ready = 1'b1;
    tick();
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    do_reset();
    check_val("rst_ctrl_en", 32'(ctrl_en), 32'd0);
    check_val("rst_busy", 32'(busy), 32'd0);
    check_val("rst_pending", 32'(pending), 32'd0);
    check_val("rst_overflow", 32'(overflow), 32'd0);
    check_val("rst_fields", {ctrl_move_dir, ctrl_msg_type, ctrl_card, ctrl_sel_len,
                             ctrl_block_x, ctrl_block_y}, 32'd0);

    // Single request from source 1
    set_src(1, 1'b1, 4'h5, 6'd17, 3'd3, 5'd21, 3'd6);
    pulse(4'b0010);
    check_val("single_pending", 32'(pending), 32'b0010);
    check_val("single_early_en", 32'(ctrl_en), 32'd0);
    expect_issue("single", 6'd17);
    check_val("single_type", 32'(ctrl_msg_type), 32'h5);
    check_val("single_dir", 32'(ctrl_move_dir), 32'd1);
    check_val("single_sel", 32'(ctrl_sel_len), 32'd3);
    check_val("single_bx", 32'(ctrl_block_x), 32'd21);
    check_val("single_by", 32'(ctrl_block_y), 32'd6);
    check_val("single_pending_clr", 32'(pending), 32'd0);
    check_val("single_busy", 32'(busy), 32'd1);
    inter_ready = 1'b0;
    tick();
    check_val("single_one_pulse", 32'(ctrl_en), 32'd0);
    tick();
    check_val("single_wait_busy", 32'(busy), 32'd1);
    inter_ready = 1'b1;
    tick();
    check_val("single_idle", 32'(busy), 32'd0);
    check_val("single_hold_card", 32'(ctrl_card), 32'd17);
    check_val("single_no_more", 32'(ctrl_en), 32'd0);

    // Round-robin from a fresh reset
    do_reset();
    for (int i = 0; i < N_SRC; i++) set_src(i, 1'b0, 4'(i + 8), 6'(10 + i), 3'd0, 5'd0, 3'd0);
    pulse(4'b1111);
    check_val("rr_pending", 32'(pending), 32'b1111);
    expect_issue("rr_g0", 6'd10);
    check_val("rr_pending_g0", 32'(pending), 32'b1110);
    xmit_cycle();
    expect_issue("rr_g1", 6'd11);
    xmit_cycle();
    expect_issue("rr_g2", 6'd12);
    xmit_cycle();
    expect_issue("rr_g3", 6'd13);
    check_val("rr_g3_type", 32'(ctrl_msg_type), 32'd11);
    check_val("rr_drained", 32'(pending), 32'd0);
    xmit_cycle();
    set_src(0, 1'b0, 4'h1, 6'd20, 3'd0, 5'd0, 3'd0);
    set_src(3, 1'b0, 4'h2, 6'd23, 3'd0, 5'd0, 3'd0);
    pulse(4'b1001);
    expect_issue("rr2_first", 6'd20);
    xmit_cycle();
    expect_issue("rr2_second", 6'd23);
    xmit_cycle();

    // Overflow while the transmitter is held busy
    inter_ready = 1'b0;
    set_src(2, 1'b0, 4'h3, 6'd1, 3'd0, 5'd0, 3'd0);
    pulse(4'b0100);
    set_src(2, 1'b0, 4'h3, 6'd2, 3'd0, 5'd0, 3'd0);
    pulse(4'b0100);
    check_val("ovf_flag", 32'(overflow), 32'b0100);
    check_val("ovf_pending", 32'(pending), 32'b0100);
    tick();
    check_val("ovf_held", 32'(ctrl_en), 32'd0);
    inter_ready = 1'b1;
    expect_issue("ovf_issue", 6'd1);
    xmit_cycle();
    tick();
    check_val("ovf_single", 32'(ctrl_en), 32'd0);
    check_val("ovf_empty", 32'(pending), 32'd0);
    check_val("ovf_sticky", 32'(overflow), 32'b0100);

    // Refill in the grant cycle
    do_reset();
    check_val("refill_ovf_cleared", 32'(overflow), 32'd0);
    set_src(0, 1'b0, 4'h4, 6'd8, 3'd0, 5'd0, 3'd0);
    src_en = 4'b0001;
    tick();
    set_src(0, 1'b0, 4'h4, 6'd9, 3'd0, 5'd0, 3'd0);
    tick();
    src_en = '0;
    check_val("refill_first_en", 32'(ctrl_en), 32'd1);
    check_val("refill_first_card", 32'(ctrl_card), 32'd8);
    check_val("refill_pending", 32'(pending), 32'b0001);
    check_val("refill_no_ovf", 32'(overflow), 32'd0);
    xmit_cycle();
    expect_issue("refill_second", 6'd9);
    check_val("refill_no_ovf2", 32'(overflow), 32'd0);
    xmit_cycle();

    // Timeout with inter_ready stuck high
    set_src(1, 1'b0, 4'h6, 6'd30, 3'd0, 5'd0, 3'd0);
    set_src(2, 1'b0, 4'h7, 6'd31, 3'd0, 5'd0, 3'd0);
    pulse(4'b0110);
    expect_issue("to_first", 6'd30);
    for (int c = 0; c < 3; c++) begin
      tick();
      check_val("to_wait_en", 32'(ctrl_en), 32'd0);
      check_val("to_wait_busy", 32'(busy), 32'd1);
    end
    tick();
    check_val("to_idle", 32'(busy), 32'd0);
    expect_issue("to_second", 6'd31);
    tick();
    tick();
    tick();
    tick();
    check_val("to_idle2", 32'(busy), 32'd0);

    // Reset in WAIT_DONE with three sources still pending
    for (int i = 0; i < N_SRC; i++) set_src(i, 1'b1, 4'hf, 6'(40 + i), 3'd7, 5'd31, 3'd7);
    pulse(4'b1111);
    expect_issue("mid_first", 6'd43);
    check_val("mid_pending", 32'(pending), 32'b0111);
    inter_ready = 1'b0;
    tick();
    tick();
    check_val("mid_wait_done", 32'(busy), 32'd1);
    interboard_rst = 1'b1;
    src_en = 4'b1000;
    tick();
    interboard_rst = 1'b0;
    src_en = '0;
    check_val("mid_rst_en", 32'(ctrl_en), 32'd0);
    check_val("mid_rst_busy", 32'(busy), 32'd0);
    check_val("mid_rst_pending", 32'(pending), 32'd0);
    check_val("mid_rst_ovf", 32'(overflow), 32'd0);
    check_val("mid_rst_fields", {ctrl_move_dir, ctrl_msg_type, ctrl_card, ctrl_sel_len,
                                 ctrl_block_x, ctrl_block_y}, 32'd0);
    inter_ready = 1'b1;
    for (int c = 0; c < 5; c++) begin
      tick();
      check_val("mid_quiet", 32'(ctrl_en), 32'd0);
    end
    set_src(0, 1'b0, 4'h1, 6'd50, 3'd0, 5'd0, 3'd0);
    set_src(2, 1'b0, 4'h1, 6'd52, 3'd0, 5'd0, 3'd0);
    pulse(4'b0101);
    expect_issue("mid_after_src0", 6'd50);
    xmit_cycle();
    expect_issue("mid_after_src2", 6'd52);
    xmit_cycle();
    check_val("final_pending", 32'(pending), 32'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/ctrl_msg_arbiter.md
# ctrl_msg_arbiter

Merges the control-message requests of the GameControl handlers (one-win, reset-table, draw, move, …) into the single `ctrl_*` request bus that drives the interboard transmitter. Each handler fires a one-cycle `*_ctrl_en` pulse with its message fields. The arbiter buffers one request per source and grants buffered requests round-robin. It forwards each grant as a one-cycle `ctrl_en` pulse, then waits for the transmitter's `inter_ready` busy/idle cycle to finish before it issues the next message. It sits directly downstream of the `handle_*` blocks and upstream of the interboard send logic.

## Interface
- `N_SRC`, default 4: number of handler sources. Source *i* occupies slice `[i*W +: W]` of every packed `src_*` input.
- `BUSY_TIMEOUT`, default 3: number of cycles to wait in WAIT_BUSY for `inter_ready` to drop.
- `clk`  in  1  system clock; the only clock.
- `rst`  in  1  reset, synchronous, active-high.
- `interboard_rst`  in  1  synchronous, active-high; same effect as `rst`.
- `inter_ready`  in  1  transmitter idle flag.
- `src_en`  in  N_SRC  per-source request pulse.
- `src_move_dir`  in  N_SRC  packed, 1b per source.
- `src_msg_type`  in  4·N_SRC  packed.
- `src_card`  in  6·N_SRC  packed.
- `src_sel_len`  in  3·N_SRC  packed.
- `src_block_x`  in  5·N_SRC  packed.
- `src_block_y`  in  3·N_SRC  packed.
- `ctrl_en`  out  1  one-cycle message-issue pulse to the transmitter.
- `ctrl_move_dir`, `ctrl_msg_type`, `ctrl_card`, `ctrl_sel_len`, `ctrl_block_x`, `ctrl_block_y`  out  1/4/6/3/5/3  fields of the granted message.
- `pending`  out  N_SRC  buffer-full flag per source.
- `overflow`  out  N_SRC  sticky flag per source: a request was dropped.
- `busy`  out  1  high when state ≠ IDLE.

## Operation
- **Per-source buffer, one entry deep.**
  - A cycle with `src_en[i]=1` captures source *i*'s fields and sets `pending[i]`.
  - If `pending[i]` is already 1 and the entry is not granted in that same cycle, the new request is dropped, the old entry is kept, and `overflow[i]` sets.
  - If the entry is granted in that same cycle, the granted (old) entry goes out and the new request fills the buffer. `pending[i]` stays 1 and there is no overflow.
- **Arbitration is round-robin.** The winner is the first pending source at index strictly after `last_grant`, wrapping modulo `N_SRC`. `last_grant` resets to `N_SRC-1`, so source 0 wins first.
- **State machine:**
  - **IDLE:** if `|pending` and `inter_ready`, go to SEND. In the same edge, load the `ctrl_*` fields from the winner, clear its `pending` bit, and update `last_grant`.
  - **SEND:** `ctrl_en=1` for exactly this cycle; go to WAIT_BUSY.
  - **WAIT_BUSY:** if `inter_ready=0`, go to WAIT_DONE. After `BUSY_TIMEOUT` consecutive cycles with `inter_ready=1`, treat the message as consumed and go to IDLE.
  - **WAIT_DONE:** when `inter_ready=1`, go to IDLE.
- `ctrl_*` fields hold the last granted values whenever `ctrl_en=0`. They change only on the IDLE→SEND edge.
- `rst` or `interboard_rst` mid-operation:
  - state goes to IDLE; `pending`, `overflow`, `ctrl_en`, and all `ctrl_*` fields go to 0; `last_grant` goes to `N_SRC-1`.
  - a `src_en` pulse in the reset cycle is discarded.
- Reset values: every output is 0.

## Timing
- A capture at edge *t* (`src_en` high in cycle *t*) makes `pending` visible in cycle *t+1*.
- If the arbiter is IDLE with `inter_ready=1` in *t+1*, `ctrl_en` is high in *t+2*. Best-case request-to-issue latency is 2 cycles.
- The transmitter drops `inter_ready` within 1 cycle of `ctrl_en`. The timeout covers a transmitter that completes instantly.
- Minimum spacing between `ctrl_en` pulses is 4 cycles: SEND, WAIT_BUSY, WAIT_DONE (ready=1), IDLE, then the next SEND.
- All outputs are registered. There is no combinational path from `src_*` or `inter_ready` to any output.

## Test plan
- **Single request.**
  - Stimulus: after reset, pulse `src_en=4'b0010` with `msg_type=4'h5`, `card=6'd17`; `inter_ready=1`, dropping to 0 for 2 cycles after `ctrl_en`.
  - Required: exactly one `ctrl_en` pulse 2 cycles after the request, with `ctrl_msg_type=5` and `ctrl_card=17`; `pending` returns to 0.
- **Round-robin.**
  - Stimulus: pulse `src_en=4'b1111` once.
  - Required: grant order 0, 1, 2, 3. Then pulse sources 0 and 3 together: grant order 0, 3, and no source is granted twice in a row while another is pending.
- **Overflow.**
  - Stimulus: hold `inter_ready=0`; pulse `src_en[2]` twice with `card=1` and then `card=2`.
  - Required: `overflow[2]=1`; after `inter_ready` rises, the single `ctrl_en` carries `card=1`.
- **Refill on grant.**
  - Stimulus: pulse `src_en[0]` (`card=9`) in the exact cycle source 0 is granted with `card=8`.
  - Required: `card=8` is issued first, then `card=9`; `overflow` stays 0.
- **Timeout.**
  - Stimulus: `inter_ready` stuck at 1.
  - Required: after `ctrl_en`, the arbiter returns to IDLE after 3 WAIT_BUSY cycles; the next pending message issues.
- **Reset mid-operation.**
  - Stimulus: assert `interboard_rst` in WAIT_DONE with 3 sources pending.
  - Required: next cycle all outputs are 0, `busy=0`; no `ctrl_en` follows without new requests; the next request grants source 0 first.
